uart_tx_buffer: RTL and testbench

//  Memory-mapped byte buffer between the core's store path and the UART transmitter.
//  - CPU stores to DATA are queued in a FIFO.
//  - Bytes are drained one at a time as a single-cycle write strobe plus data to the transmitter, paced by its busy flag.
//  - CPU polls STATUS to avoid overflow; the buffer smooths bursts of prints.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/byte_fifo.sv | 66 ++++++
 rtl/uart_tx_buffer.sv | 143 ++++++++++++++
 tb/tb_uart_tx_buffer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register map, status layout and FSM state type for the UART TX buffer
package uart_pkg;

    localparam logic [31:0] UART_DATA_OFS   = 32'h0000_0000;
    localparam logic [31:0] UART_STATUS_OFS = 32'h0000_0004;

    localparam int STAT_OVF_BIT   = 15;
    localparam int STAT_FULL_BIT  = 14;
    localparam int STAT_EMPTY_BIT = 13;

    typedef enum logic [1:0] {
        TXB_IDLE = 2'd0,
        TXB_SEND = 2'd1,
        TXB_GAP  = 2'd2
    } txb_state_e;

    // Packs the STATUS word: flags in the upper byte of the low half, count in the low byte.
    function automatic logic [31:0] status_word(input logic ovf, input logic full,
                                                input logic empty, input logic [7:0] cnt);
        logic [31:0] w;
        w                 = 32'h0;
        w[STAT_OVF_BIT]   = ovf;
        w[STAT_FULL_BIT]  = full;
        w[STAT_EMPTY_BIT] = empty;
        w[7:0]            = cnt;
        return w;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous FIFO with registered read data and occupancy count
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] dout_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = dout_q;

    // A push into a full FIFO is only safe when the same cycle frees a slot.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); read data is captured on pop and held.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                dout_q   <= mem_q[rd_ptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// rtl/uart_tx_buffer.sv - MMIO byte queue that paces bytes into a UART transmitter
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int          DEPTH      = 16,
    parameter logic [31:0] BASE_ADDR  = 32'hF000_0000,
    parameter int          GAP_CYCLES = 2
) (
    input  logic        sys_clk_i,
    input  logic        sys_rstn_i,
    input  logic        bus_we_i,
    input  logic        bus_re_i,
    input  logic [31:0] bus_addr_i,
    input  logic [31:0] bus_wdata_i,
    output logic [31:0] bus_rdata_o,
    input  logic        uart_busy_i,
    output logic        uart_wr_o,
    output logic [7:0]  uart_dat_o,
    output logic        overflow_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    logic          sel_data;
    logic          sel_stat;
    logic          data_store;
    logic          push_drop;
    logic          ovf_clear;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_dout;
    logic [7:0]    cnt8;

    logic          ovf_q;
    logic          ovf_d;
    logic [31:0]   rdata_q;
    logic [31:0]   rdata_d;
    txb_state_e    state_q;
    logic          wr_q;
    logic [GW-1:0] gap_q;

    logic          unused_wdata;
    assign unused_wdata = ^{bus_wdata_i[31:16], bus_wdata_i[14:8]};

    assign sel_data   = (bus_addr_i == BASE_ADDR + UART_DATA_OFS);
    assign sel_stat   = (bus_addr_i == BASE_ADDR + UART_STATUS_OFS);
    assign data_store = bus_we_i && sel_data;

    // The head is taken only from IDLE, after the gap has expired and busy is low.
    assign fifo_pop   = (state_q == TXB_IDLE) && !fifo_empty && !uart_busy_i;
    assign push_drop  = data_store && fifo_full && !fifo_pop;
    assign ovf_clear  = bus_we_i && sel_stat && bus_wdata_i[STAT_OVF_BIT];
    assign cnt8       = 8'(fifo_count);

    byte_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (sys_clk_i),
        .rst_ni  (sys_rstn_i),
        .push_i  (data_store),
        .pop_i   (fifo_pop),
        .din_i   (bus_wdata_i[7:0]),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Sticky overflow: a dropped byte sets it and beats a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (push_drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clear) begin
            ovf_d = 1'b0;
        end
    end

    // Load data: STATUS reflects the state in the cycle of the load; everything else reads 0.
    always_comb begin
        rdata_d = 32'h0;
        if (bus_re_i && sel_stat) begin
            rdata_d = status_word(ovf_q, fifo_full, fifo_empty, cnt8);
        end
    end

    // Register file outputs: overflow flag and load-return data.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            ovf_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
        end
    end

    // Drain FSM: one-cycle strobe, then a hold-off so a late-rising busy is seen before the next pop.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            state_q <= TXB_IDLE;
            wr_q    <= 1'b0;
            gap_q   <= '0;
        end else begin
            case (state_q)
                TXB_IDLE: begin
                    if (fifo_pop) begin
                        wr_q    <= 1'b1;
                        state_q <= TXB_SEND;
                    end
                end
                TXB_SEND: begin
                    wr_q    <= 1'b0;
                    gap_q   <= GW'(GAP_CYCLES);
                    state_q <= TXB_GAP;
                end
                TXB_GAP: begin
                    if (gap_q <= GW'(1)) begin
                        gap_q   <= '0;
                        state_q <= TXB_IDLE;
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                default: begin
                    wr_q    <= 1'b0;
                    gap_q   <= '0;
                    state_q <= TXB_IDLE;
                end
            endcase
        end
    end

    assign uart_wr_o   = wr_q;
    assign uart_dat_o  = fifo_dout;
    assign overflow_o  = ovf_q;
    assign bus_rdata_o = rdata_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb/tb_uart_tx_buffer.sv - scoreboard bench for the UART TX buffer
module tb_uart_tx_buffer;

    localparam logic [31:0] BASE = 32'hF000_0000;
    localparam logic [31:0] STAT = 32'hF000_0004;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        uart_busy;
    logic        uart_wr;
    logic [7:0]  uart_dat;
    logic        ovf;

    logic        man_busy = 1'b0;
    logic        model_en = 1'b0;
    logic        model_busy = 1'b0;
    logic        strobe_pending = 1'b0;
    int          busy_left = 0;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          strobe_cnt = 0;
    int          last_strobe_cyc = -100;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;

    assign uart_busy = model_en ? model_busy : man_busy;

    uart_tx_buffer dut (
        .sys_clk_i   (clk),
        .sys_rstn_i  (rst_n),
        .bus_we_i    (we),
        .bus_re_i    (re),
        .bus_addr_i  (addr),
        .bus_wdata_i (wdata),
        .bus_rdata_o (rdata),
        .uart_busy_i (uart_busy),
        .uart_wr_o   (uart_wr),
        .uart_dat_o  (uart_dat),
        .overflow_o  (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: every strobe must match the scoreboard head, avoid busy, and be spaced out.
    always @(negedge clk) begin
        if (rst_n && uart_wr) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL strobe_unexpected got dat=%02h want=no strobe", uart_dat);
            end else begin
                mon_exp = exp_q.pop_front();
                if (uart_dat !== mon_exp) begin
                    bad++;
                    $display("FAIL strobe_data got=%02h want=%02h", uart_dat, mon_exp);
                end
            end
            total++;
            if (uart_busy !== 1'b0) begin
                bad++;
                $display("FAIL strobe_while_busy got busy=%b want=0", uart_busy);
            end
            total++;
            if (cyc - last_strobe_cyc < 3) begin
                bad++;
                $display("FAIL strobe_spacing got=%0d want>=3", cyc - last_strobe_cyc);
            end
            last_strobe_cyc = cyc;
            strobe_cnt++;
            strobe_pending = 1'b1;
        end
    end

    // Transmitter model: busy rises the cycle after a strobe and stays high for 10 cycles.
    always @(posedge clk) begin
        #1;
        if (model_en) begin
            if (busy_left > 0) busy_left--;
            if (strobe_pending) busy_left = 10;
            model_busy = (busy_left > 0);
        end
        strobe_pending = 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1;
        addr = a;
        wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
        addr = 32'h0;
        wdata = 32'h0;
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] d);
        re = 1'b1;
        addr = a;
        @(posedge clk);
        #1;
        re = 1'b0;
        addr = 32'h0;
        d = rdata;
    endtask

    task automatic wait_strobes(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (strobe_cnt >= target) break;
            @(posedge clk);
            #1;
        end
        total++;
        if (strobe_cnt < target) begin
            bad++;
            $display("FAIL strobe_timeout got=%0d want=%0d", strobe_cnt, target);
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        #12;
        total++; if (uart_wr !== 1'b0)   begin bad++; $display("FAIL rst_wr got=%b want=0", uart_wr); end
        total++; if (uart_dat !== 8'h00) begin bad++; $display("FAIL rst_dat got=%02h want=00", uart_dat); end
        total++; if (rdata !== 32'h0)    begin bad++; $display("FAIL rst_rdata got=%08h want=0", rdata); end
        total++; if (ovf !== 1'b0)       begin bad++; $display("FAIL rst_ovf got=%b want=0", ovf); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        load(STAT, d);
        total++; if (d !== 32'h0000_2000) begin bad++; $display("FAIL rst_status got=%08h want=00002000", d); end
        load(BASE + 32'h8, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%08h want=0", d); end
    endtask

    task automatic test_single;
        int c0;
        int sc;
        c0 = strobe_cnt;
        exp_q.push_back(8'h41);
        sc = cyc;
        store(BASE, 32'h0000_0041);
        wait_strobes(c0 + 1, 20);
        total++;
        if (last_strobe_cyc - sc !== 2) begin
            bad++;
            $display("FAIL single_latency got=%0d want=2", last_strobe_cyc - sc);
        end
        idle(3);
        total++; if (uart_dat !== 8'h41) begin bad++; $display("FAIL dat_hold got=%02h want=41", uart_dat); end
        total++; if (uart_wr !== 1'b0)   begin bad++; $display("FAIL wr_after got=%b want=0", uart_wr); end
        idle(8);
    endtask

    task automatic test_fill;
        logic [31:0] d;
        int c0;
        man_busy = 1'b1;
        c0 = strobe_cnt;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(i));
            store(BASE, 32'(i));
        end
        idle(4);
        total++; if (strobe_cnt !== c0) begin bad++; $display("FAIL fill_no_strobe got=%0d want=%0d", strobe_cnt, c0); end
        load(STAT, d);
        total++; if (d !== 32'h0000_4010) begin bad++; $display("FAIL fill_status got=%08h want=00004010", d); end
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        store(BASE, 32'h0000_00FF);
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", ovf); end
        load(STAT, d);
        total++; if (d !== 32'h0000_C010) begin bad++; $display("FAIL ovf_status got=%08h want=0000c010", d); end
        store(STAT, 32'h0000_8000);
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", ovf); end
    endtask

    task automatic test_push_pop;
        logic [31:0] d;
        int c0;
        c0 = strobe_cnt;
        man_busy = 1'b0;
        exp_q.push_back(8'h80);
        store(BASE, 32'h0000_0080);
        load(STAT, d);
        total++; if (d !== 32'h0000_4010) begin bad++; $display("FAIL pushpop_status got=%08h want=00004010", d); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL pushpop_ovf got=%b want=0", ovf); end
        wait_strobes(c0 + 17, 400);
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL drain_left got=%0d want=0", exp_q.size()); end
        idle(8);
        load(STAT, d);
        total++; if (d !== 32'h0000_2000) begin bad++; $display("FAIL drain_status got=%08h want=00002000", d); end
    endtask

    task automatic test_busy_model;
        int c0;
        int s_prev;
        model_en = 1'b1;
        c0 = strobe_cnt;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'hA0 + 8'(i));
            store(BASE, 32'h0000_00A0 + 32'(i));
        end
        wait_strobes(c0 + 1, 20);
        for (int k = 2; k <= 3; k++) begin
            s_prev = last_strobe_cyc;
            wait_strobes(c0 + k, 60);
            total++;
            if (last_strobe_cyc - s_prev < 12) begin
                bad++;
                $display("FAIL busy_pacing got=%0d want>=12", last_strobe_cyc - s_prev);
            end
        end
        idle(15);
        model_en = 1'b0;
        idle(2);
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        int c0;
        man_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'h50 + 8'(i));
            store(BASE, 32'h0000_0050 + 32'(i));
        end
        idle(2);
        man_busy = 1'b0;
        @(posedge clk);
        #1;
        total++; if (uart_wr !== 1'b1) begin bad++; $display("FAIL mid_send got=%b want=1", uart_wr); end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (uart_wr !== 1'b0)   begin bad++; $display("FAIL mid_rst_wr got=%b want=0", uart_wr); end
        total++; if (uart_dat !== 8'h00) begin bad++; $display("FAIL mid_rst_dat got=%02h want=00", uart_dat); end
        exp_q.delete();
        c0 = strobe_cnt;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        load(STAT, d);
        total++; if (d !== 32'h0000_2000) begin bad++; $display("FAIL mid_status got=%08h want=00002000", d); end
        idle(30);
        total++; if (strobe_cnt !== c0) begin bad++; $display("FAIL mid_no_strobe got=%0d want=%0d", strobe_cnt, c0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_overflow();
        test_push_pop();
        test_busy_model();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
